// File: rtl/bdcpu_program_loader_pkg.sv
// Shared definitions for the bdcpu program loader slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default memory geometry and the loader state encoding, which is
// also exported on the loader's state port (0=IDLE, 1=LOAD, 2=RUN).
package bdcpu_program_loader_pkg;

    localparam int BDCPU_ADDR_WIDTH = 4;
    localparam int BDCPU_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } bdcpu_state_e;

endpackage

// File: rtl/bdcpu_program_loader_if.sv
// Program byte stream and load/stop control into the bdcpu program loader.
// Latency: n/a (wiring only).
// Backpressure: ready is driven by the loader; a beat transfers on valid && ready.
// Signals: start/stop pulses, valid/ready/data/last byte stream.
// Modports: master = stream source, slave = loader.
interface bdcpu_program_loader_if
    import bdcpu_program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = BDCPU_DATA_WIDTH
);
    logic                  start;
    logic                  stop;
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output start, output stop, output valid, output data, output last,
                    input ready);
    modport slave  (input start, input stop, input valid, input data, input last,
                    output ready);
endinterface

// File: rtl/bdcpu_program_memory.sv
// Program memory: one synchronous write port, two asynchronous read ports.
// Latency: write visible on reads right after the posedge; reads are combinational.
// Backpressure: none; the write port is always accepted.
// Ports: clock, write_en/write_addr/write_data, cpu_addr->cpu_data, dbg_addr->dbg_data.
// Contents are deliberately not reset so a program survives a system reset.
module bdcpu_program_memory
    import bdcpu_program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = BDCPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = BDCPU_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign cpu_data = mem[cpu_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/bdcpu_program_loader.sv
// Boot/ownership controller: streams a program into memory with the CPU held in reset, then runs it.
// Latency: a beat is written on its accepting edge; RUN and cpu_reset_n=1 follow the final beat's edge.
// Backpressure: load.ready is high exactly while in LOAD; no buffering.
// Ports: clock, reset (async active-low), load (stream interface), cpu_reset_n,
//        cpu_mem_* (CPU memory bus, data bidirectional), dbg_addr/dbg_data, state, load_count, timeout.
module bdcpu_program_loader
    import bdcpu_program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = BDCPU_ADDR_WIDTH,
    parameter int DATA_WIDTH = BDCPU_DATA_WIDTH,
    parameter int RUN_LIMIT  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    bdcpu_program_loader_if.slave load,
    output logic                  cpu_reset_n,
    input  logic                  cpu_mem_output,
    input  logic                  cpu_mem_write,
    input  logic [ADDR_WIDTH-1:0] cpu_mem_address,
    inout  wire  [DATA_WIDTH-1:0] cpu_mem_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  timeout
);
    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

    // Watchdog counter only needs to reach RUN_LIMIT-1.
    localparam int WD_W = (RUN_LIMIT > 2) ? $clog2(RUN_LIMIT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((RUN_LIMIT == 0) ? 0 : RUN_LIMIT - 1);

    bdcpu_state_e          state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [WD_W-1:0]       wd_cnt_q;

    logic                  beat;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rd_en;

    assign state      = state_q;
    assign load.ready = (state_q == ST_LOAD);

    // start and stop take priority over a beat presented in the same cycle.
    assign beat = (state_q == ST_LOAD) && load.valid && !load.start && !load.stop;

    // Write port ownership: loader while in LOAD, CPU while in RUN, nobody otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = load.data;
        if (beat) begin
            mem_we = 1'b1;
        end else if ((state_q == ST_RUN) && cpu_mem_write) begin
            mem_we    = 1'b1;
            mem_waddr = cpu_mem_address;
            mem_wdata = cpu_mem_data;
        end
    end

    assign cpu_rd_en    = (state_q == ST_RUN) && cpu_mem_output && !cpu_mem_write;
    assign cpu_mem_data = cpu_rd_en ? cpu_rdata : {DATA_WIDTH{1'bz}};

    bdcpu_program_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clock      (clock),
        .write_en   (mem_we),
        .write_addr (mem_waddr),
        .write_data (mem_wdata),
        .cpu_addr   (cpu_mem_address),
        .cpu_data   (cpu_rdata),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // cpu_reset_n is registered alongside the state so it changes on the same
    // edge as entry to / exit from RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cpu_reset_n <= 1'b0;
            ptr_q       <= '0;
            load_count  <= '0;
            timeout     <= 1'b0;
            wd_cnt_q    <= '0;
        end else if (load.start) begin
            state_q     <= ST_LOAD;
            cpu_reset_n <= 1'b0;
            ptr_q       <= '0;
            load_count  <= '0;
            timeout     <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load.stop) begin
                        state_q <= ST_IDLE;
                    end else if (beat) begin
                        ptr_q <= ptr_q + ADDR_WIDTH'(1);
                        if (load_count != DEPTH_COUNT) begin
                            load_count <= load_count + (ADDR_WIDTH+1)'(1);
                        end
                        // Filling the last address ends the load even without load.last.
                        if (load.last || (ptr_q == {ADDR_WIDTH{1'b1}})) begin
                            state_q     <= ST_RUN;
                            cpu_reset_n <= 1'b1;
                            wd_cnt_q    <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (load.stop) begin
                        state_q     <= ST_IDLE;
                        cpu_reset_n <= 1'b0;
                    end else if ((RUN_LIMIT != 0) && (wd_cnt_q == WD_LAST)) begin
                        state_q     <= ST_IDLE;
                        cpu_reset_n <= 1'b0;
                        timeout     <= 1'b1;
                    end else if (wd_cnt_q != {WD_W{1'b1}}) begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cpu_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bdcpu_program_loader.sv
`timescale 1ns/1ps
module tb_bdcpu_program_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_reset_n;
    logic       cpu_mem_output = 1'b0;
    logic       cpu_mem_write  = 1'b0;
    logic [3:0] cpu_mem_address = '0;
    wire  [7:0] cpu_mem_data;
    logic [7:0] drv_dat = '0;
    logic       drv_en  = 1'b0;
    logic [3:0] dbg_addr = '0;
    logic [7:0] dbg_data;
    logic [1:0] state;
    logic [4:0] load_count;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: expected memory image.
    logic [7:0] ref_mem [16];
    logic [7:0] old_mem [16];

    assign cpu_mem_data = drv_en ? drv_dat : 8'bz;

    bdcpu_program_loader_if #(.DATA_WIDTH(8)) lif ();

    bdcpu_program_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RUN_LIMIT(8)) dut (
        .clock           (clock),
        .reset           (reset),
        .load            (lif),
        .cpu_reset_n     (cpu_reset_n),
        .cpu_mem_output  (cpu_mem_output),
        .cpu_mem_write   (cpu_mem_write),
        .cpu_mem_address (cpu_mem_address),
        .cpu_mem_data    (cpu_mem_data),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data),
        .state           (state),
        .load_count      (load_count),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL time_limit simulation did not finish, got running, expected done");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start;
        lif.start = 1'b1;
        tick();
        lif.start = 1'b0;
    endtask

    task automatic pulse_stop;
        lif.stop = 1'b1;
        tick();
        lif.stop = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        lif.valid = 1'b1;
        lif.data  = d;
        lif.last  = last;
        tick();
        lif.valid = 1'b0;
        lif.last  = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_reset_n got %b exp 0", cpu_reset_n); end
        n_cmp++; if (lif.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b exp 0", lif.ready); end
        n_cmp++; if (load_count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d exp 0", load_count); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    endtask

    task automatic test_full_load;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (lif.ready !== 1'b1) begin n_bad++; $display("FAIL full_ready beat %0d got %b exp 1", i, lif.ready); end
            send_beat(8'(i), 1'b0);
            ref_mem[i] = 8'(i);
        end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL full_state got %0d exp 2", state); end
        n_cmp++; if (lif.ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_after got %b exp 0", lif.ready); end
        n_cmp++; if (load_count !== 5'd16) begin n_bad++; $display("FAIL full_count got %0d exp 16", load_count); end
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_bad++; $display("FAIL full_cpu_reset_n got %b exp 1", cpu_reset_n); end
        pulse_stop();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            n_cmp++; if (dbg_data !== ref_mem[i]) begin n_bad++; $display("FAIL full_mem[%0d] got %h exp %h", i, dbg_data, ref_mem[i]); end
        end
    endtask

    task automatic test_load_last3;
        logic [7:0] prog [3];
        prog[0] = 8'h51; prog[1] = 8'h4E; prog[2] = 8'h50;
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL last3_cpu_held beat %0d got %b exp 0", i, cpu_reset_n); end
            send_beat(prog[i], i == 2);
            ref_mem[i] = prog[i];
        end
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL last3_state got %0d exp 2", state); end
        n_cmp++; if (cpu_reset_n !== 1'b1) begin n_bad++; $display("FAIL last3_cpu_reset_n got %b exp 1", cpu_reset_n); end
        n_cmp++; if (load_count !== 5'd3) begin n_bad++; $display("FAIL last3_count got %0d exp 3", load_count); end
        pulse_stop();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL last3_stop_state got %0d exp 0", state); end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL last3_stop_cpu got %b exp 0", cpu_reset_n); end
        n_cmp++; if (load_count !== 5'd3) begin n_bad++; $display("FAIL last3_count_held got %0d exp 3", load_count); end
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            n_cmp++; if (dbg_data !== ref_mem[i]) begin n_bad++; $display("FAIL last3_mem[%0d] got %h exp %h", i, dbg_data, ref_mem[i]); end
        end
    endtask

    task automatic test_cpu_access;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        pulse_start();
        send_beat(d, 1'b1);
        ref_mem[0] = d;
        cpu_mem_write = 1'b1; cpu_mem_address = 4'hE; drv_dat = 8'hAB; drv_en = 1'b1;
        tick();
        cpu_mem_write = 1'b0; drv_en = 1'b0;
        ref_mem[14] = 8'hAB;
        cpu_mem_output = 1'b1; cpu_mem_address = 4'hE; dbg_addr = 4'hE; #1;
        n_cmp++; if (cpu_mem_data !== 8'hAB) begin n_bad++; $display("FAIL cpu_read got %h exp ab", cpu_mem_data); end
        n_cmp++; if (dbg_data !== 8'hAB) begin n_bad++; $display("FAIL cpu_write_dbg got %h exp ab", dbg_data); end
        cpu_mem_output = 1'b0;
        pulse_start();
        cpu_mem_write = 1'b1; cpu_mem_address = 4'hE; drv_dat = 8'h12; drv_en = 1'b1;
        tick();
        cpu_mem_write = 1'b0; drv_en = 1'b0;
        dbg_addr = 4'hE; #1;
        n_cmp++; if (dbg_data !== 8'hAB) begin n_bad++; $display("FAIL cpu_write_in_load got %h exp ab", dbg_data); end
        pulse_stop();
    endtask

    task automatic test_watchdog;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        pulse_start();
        send_beat(d, 1'b1);
        ref_mem[0] = d;
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL wd_run cycle %0d got %0d exp 2", k, state); end
            tick();
        end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL wd_state got %0d exp 0", state); end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL wd_cpu_reset_n got %b exp 0", cpu_reset_n); end
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL wd_timeout got %b exp 1", timeout); end
        n_cmp++; if (load_count !== 5'd1) begin n_bad++; $display("FAIL wd_count_held got %0d exp 1", load_count); end
        tick();
        n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL wd_timeout_sticky got %b exp 1", timeout); end
        pulse_start();
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL wd_timeout_clear got %b exp 0", timeout); end
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL wd_restart_state got %0d exp 1", state); end
        pulse_stop();
    endtask

    task automatic test_reset_mid_load;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) old_mem[i] = ref_mem[i];
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom_range(0, 255));
            send_beat(d, 1'b0);
            ref_mem[i] = d;
        end
        lif.valid = 1'b1; lif.data = ~ref_mem[2];
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL midrst_state got %0d exp 0", state); end
        n_cmp++; if (lif.ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready got %b exp 0", lif.ready); end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL midrst_cpu got %b exp 0", cpu_reset_n); end
        lif.valid = 1'b0;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i); #1;
            n_cmp++; if (dbg_data !== ((i < 2) ? ref_mem[i] : old_mem[i])) begin
                n_bad++; $display("FAIL midrst_mem[%0d] got %h exp %h", i, dbg_data, (i < 2) ? ref_mem[i] : old_mem[i]);
            end
        end
        d = 8'($urandom_range(0, 255));
        pulse_start();
        send_beat(d, 1'b1);
        ref_mem[0] = d;
        n_cmp++; if (load_count !== 5'd1) begin n_bad++; $display("FAIL midrst_reload_count got %0d exp 1", load_count); end
        pulse_stop();
        dbg_addr = 4'd0; #1;
        n_cmp++; if (dbg_data !== d) begin n_bad++; $display("FAIL midrst_reload_addr0 got %h exp %h", dbg_data, d); end
    endtask

    task automatic test_start_stop_run;
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        pulse_start();
        send_beat(d, 1'b1);
        ref_mem[0] = d;
        lif.start = 1'b1; lif.stop = 1'b1;
        tick();
        lif.start = 1'b0; lif.stop = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL startstop_state got %0d exp 1", state); end
        n_cmp++; if (cpu_reset_n !== 1'b0) begin n_bad++; $display("FAIL startstop_cpu got %b exp 0", cpu_reset_n); end
        n_cmp++; if (load_count !== 5'd0) begin n_bad++; $display("FAIL startstop_count got %0d exp 0", load_count); end
        pulse_stop();
    endtask

    task automatic test_random;
        int len;
        logic [7:0] d;
        logic [3:0] a;
        for (int it = 0; it < 20; it++) begin
            len = $urandom_range(1, 16);
            pulse_start();
            for (int i = 0; i < len; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                d = 8'($urandom_range(0, 255));
                send_beat(d, (i == len - 1) && ((len < 16) || ($urandom_range(0, 1) == 1)));
                ref_mem[i] = d;
            end
            n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL rand%0d_state got %0d exp 2", it, state); end
            n_cmp++; if (load_count !== 5'(len)) begin n_bad++; $display("FAIL rand%0d_count got %0d exp %0d", it, load_count, len); end
            a = 4'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            cpu_mem_write = 1'b1; cpu_mem_address = a; drv_dat = d; drv_en = 1'b1;
            tick();
            cpu_mem_write = 1'b0; drv_en = 1'b0;
            ref_mem[a] = d;
            a = 4'($urandom_range(0, 15));
            cpu_mem_output = 1'b1; cpu_mem_address = a; #1;
            n_cmp++; if (cpu_mem_data !== ref_mem[a]) begin n_bad++; $display("FAIL rand%0d_cpu_read[%0d] got %h exp %h", it, a, cpu_mem_data, ref_mem[a]); end
            cpu_mem_output = 1'b0;
            pulse_stop();
            for (int i = 0; i < 16; i++) begin
                dbg_addr = 4'(i); #1;
                n_cmp++; if (dbg_data !== ref_mem[i]) begin n_bad++; $display("FAIL rand%0d_mem[%0d] got %h exp %h", it, i, dbg_data, ref_mem[i]); end
            end
        end
    endtask

    initial begin
        lif.start = 1'b0; lif.stop = 1'b0; lif.valid = 1'b0; lif.data = '0; lif.last = 1'b0;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; old_mem[i] = '0; end
        reset = 1'b0;
        tick(); tick(); tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_full_load();
        test_load_last3();
        test_cpu_access();
        test_watchdog();
        test_reset_mid_load();
        test_start_stop_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
